csi2_pixel_to_axis: RTL
=======================

CSI2_PIXEL_TO_AXIS -- requirements
Module: csi2_pixel_to_axis

Interface
REQ-001 SHALL have parameter LANES_NUM, default 4, pixels per input beat (1/2/4).
REQ-002 SHALL have parameter DATA_BITS, default 10, bits per pixel.
REQ-003 SHALL have parameter FIFO_ADDR_BITS, default 4, output FIFO depth = 2**FIFO_ADDR_BITS beats.
REQ-004 SHALL have port clk input 1, single clock (DPHY byte clock) for all logic.
REQ-005 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have port pix_valid input 1, packet-active flag from the CSI-2 pixel stage.
REQ-007 SHALL have port pix_di input 8, data identifier, valid with pix_valid.
REQ-008 SHALL have port pix_data input LANES_NUM*DATA_BITS, pixels, pixel 0 in LSBs.
REQ-009 SHALL have port pix_data_enable input 1, pix_data carries pixels this cycle.
REQ-010 SHALL have port m_axis_tdata output LANES_NUM*DATA_BITS, video pixels.
REQ-011 SHALL have ports m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tuser output 1 (start of frame), m_axis_tlast output 1 (end of line).
REQ-012 SHALL have port frame_count output 16, frames completed (FE seen) since reset.
REQ-013 SHALL have port line_count output 16, lines written in the last completed frame.
REQ-014 SHALL have port overflow output 1, sticky FIFO-overflow flag; port overflow_clr input 1 clears it.

Function
REQ-015 SHALL detect a packet start as pix_valid rising (low previous cycle, high now); packet end as pix_valid falling.
REQ-016 SHALL treat a packet start with pix_di[5:0]=0x00 as Frame Start (FS), 0x01 as Frame End (FE); other short codes 0x02-0x0F ignored.
REQ-017 SHALL treat a packet with pix_di[5:0]=0x2B as a line; only cycles with pix_data_enable=1 are pixel beats.
REQ-018 SHALL implement states WAIT_FS, FRAME, LINE; reset state WAIT_FS.
REQ-019 WAIT_FS: FS -> FRAME, set sof_pending; all line data discarded.
REQ-020 FRAME: line packet start -> LINE; FE -> WAIT_FS; FS -> stays FRAME, sof_pending re-set.
REQ-021 LINE: packet end -> FRAME after flushing held beat with tlast=1, line counter +1 only if line wrote >=1 beat.
REQ-022 SHALL hold each pixel beat in a one-beat register until the next pixel beat (written with tlast=0) or packet end (written with tlast=1).
REQ-023 A held beat SHALL be written to FIFO in the same cycle its successor is captured; no beat lost at back-to-back rate.
REQ-024 First beat written after FS SHALL carry tuser=1, clearing sof_pending; all others tuser=0.
REQ-025 FIFO SHALL store {tuser,tlast,tdata}; write-to-tvalid latency 1 cycle; transfer when tvalid&&tready.
REQ-026 tvalid SHALL stay high and tdata/tuser/tlast stable until accepted.
REQ-027 Write when FIFO full SHALL drop that beat and set overflow; sof_pending retained if dropped beat had tuser.
REQ-028 Simultaneous FIFO read and write when full SHALL succeed (no overflow).
REQ-029 On FE: frame_count +1 (wraps 0xFFFF->0), line_count <= lines in frame, line counter cleared; FE while LINE impossible (pix_valid contiguous) but FS/FE in WAIT_FS for FE SHALL be ignored.
REQ-030 overflow_clr SHALL clear overflow; simultaneous set and clear SHALL leave overflow=1.

Reset
REQ-031 On rst_n low: state WAIT_FS, FIFO empty, held beat invalid, sof_pending=0, m_axis_tvalid=0, tdata/tuser/tlast=0, frame_count=0, line_count=0, overflow=0.
REQ-032 Reset mid-line SHALL discard all buffered beats; no partial line output after release.

Verification
REQ-033 LANES_NUM=4: FS, one 0x2B packet with 4 enabled beats, FE, tready=1 -> 4 beats, tuser=1 on beat 0 only, tlast=1 on beat 3, frame_count=1, line_count=1.
REQ-034 Line data with no preceding FS -> no output, frame_count=0.
REQ-035 FS, 3 lines of 2 beats, FE -> 6 beats, tlast on beats 1,3,5, line_count=3.
REQ-036 tready=0, FS, 20-beat line, FIFO depth 16 -> 16 beats stored, overflow=1; overflow_clr -> overflow=0.
REQ-037 tready toggling each cycle during 8-beat line -> all 8 beats delivered in order, data stable while stalled.
REQ-038 rst_n pulsed low after 2 of 4 beats -> tvalid=0 next cycle, no further output until new FS.

Source files
------------

// File: rtl/csi2_pixel_to_axis_if.sv
// AXI4-Stream video bus carrying pixel beats out of csi2_pixel_to_axis.
//   tdata  : LANES_NUM*DATA_BITS pixels, pixel 0 in the LSBs
//   tvalid : beat available (source -> sink)
//   tready : sink accepts the beat (sink -> source)
//   tuser  : start of frame, set on the first beat after Frame Start
//   tlast  : end of line, set on the last beat of a line packet
interface csi2_pixel_to_axis_if #(
  parameter int DATA_W = 40
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/csi2_pixel_to_axis.sv
// Converts the CSI-2 pixel-stage stream (packet-active flag, data identifier,
// pixel beats) into an AXI4-Stream video stream with start-of-frame in tuser
// and end-of-line in tlast, buffered through a small output FIFO.
//   clk, rst_n       : DPHY byte clock, asynchronous active-low reset
//   pix_valid        : packet active; its rising edge is a packet start
//   pix_di           : data identifier, [5:0] is the data type
//   pix_data         : LANES_NUM pixels of DATA_BITS each, pixel 0 in LSBs
//   pix_data_enable  : pix_data carries pixels this cycle
//   m_axis           : AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   frame_count      : frames completed (Frame End seen) since reset
//   line_count       : lines written in the last completed frame
//   overflow         : sticky, set when a beat is dropped on a full FIFO
//   overflow_clr     : clears overflow (a same-cycle set wins)
module csi2_pixel_to_axis #(
  parameter int LANES_NUM      = 4,
  parameter int DATA_BITS      = 10,
  parameter int FIFO_ADDR_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pix_valid,
  input  logic [7:0]                     pix_di,
  input  logic [LANES_NUM*DATA_BITS-1:0] pix_data,
  input  logic                           pix_data_enable,
  csi2_pixel_to_axis_if.master           m_axis,
  output logic [15:0]                    frame_count,
  output logic [15:0]                    line_count,
  output logic                           overflow,
  input  logic                           overflow_clr
);

  localparam int PIX_W = LANES_NUM * DATA_BITS;
  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int ENT_W = PIX_W + 2;
  localparam logic [FIFO_ADDR_BITS:0] DEPTH_C = (FIFO_ADDR_BITS + 1)'(DEPTH);

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_LINE = 6'h2B;

  typedef enum logic [1:0] {WAIT_FS, FRAME, LINE} state_t;

  state_t state, state_nxt;

  logic             pix_valid_q;
  logic             pkt_start, pkt_end;
  logic             is_fs, is_fe, is_line;
  logic             fs_accept, fe_accept;
  logic             beat, flush;
  logic             wr_en, wr_ok, wr_user, wr_last, rd_en, ovf_set;
  logic             sof_pending;
  logic [15:0]      lines_in_frame;

  logic             hold_vld_p0;
  logic [PIX_W-1:0] hold_data_p0;

  logic [ENT_W-1:0]          mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_BITS:0]   count;
  logic                      full, empty;

  // Virtual channel bits are not used for routing in this block.
  logic [1:0] unused_vc;
  assign unused_vc = pix_di[7:6];

  assign pkt_start = pix_valid & ~pix_valid_q;
  assign pkt_end   = ~pix_valid & pix_valid_q;
  assign is_fs     = pkt_start && (pix_di[5:0] == DT_FS);
  assign is_fe     = pkt_start && (pix_di[5:0] == DT_FE);
  assign is_line   = pkt_start && (pix_di[5:0] == DT_LINE);

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rd_en = m_axis.tvalid && m_axis.tready;

  always_comb begin
    state_nxt = state;
    fs_accept = 1'b0;
    fe_accept = 1'b0;
    beat      = 1'b0;
    flush     = 1'b0;
    unique case (state)
      WAIT_FS: begin
        fs_accept = is_fs;
        if (is_fs) state_nxt = FRAME;
      end
      FRAME: begin
        fs_accept = is_fs;
        fe_accept = is_fe;
        // A line may carry pixels on its very first active cycle.
        beat      = is_line && pix_data_enable;
        if (is_line)    state_nxt = LINE;
        else if (is_fe) state_nxt = WAIT_FS;
      end
      LINE: begin
        beat  = pix_valid && pix_data_enable;
        flush = pkt_end && hold_vld_p0;
        if (pkt_end) state_nxt = FRAME;
      end
      default: state_nxt = WAIT_FS;
    endcase
    // The held beat leaves either when a successor arrives or at line end;
    // the two cannot coincide because a line end has pix_valid low.
    wr_en   = (beat && hold_vld_p0) || flush;
    wr_last = flush;
    wr_user = sof_pending;
    // A read on the same edge frees the slot, so a full FIFO still accepts.
    wr_ok   = wr_en && (!full || rd_en);
    ovf_set = wr_en && !wr_ok;
  end

  // Stage boundary: packet tracking, held beat, frame/line bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT_FS;
      pix_valid_q    <= 1'b0;
      hold_vld_p0    <= 1'b0;
      sof_pending    <= 1'b0;
      lines_in_frame <= '0;
      frame_count    <= '0;
      line_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pix_valid_q <= pix_valid;

      if (beat)         hold_vld_p0 <= 1'b1;
      else if (pkt_end) hold_vld_p0 <= 1'b0;

      // A dropped start-of-frame beat keeps sof_pending for the next write.
      if (fs_accept)              sof_pending <= 1'b1;
      else if (wr_ok && wr_user)  sof_pending <= 1'b0;

      if (fe_accept) begin
        frame_count    <= frame_count + 16'd1;
        line_count     <= lines_in_frame;
        lines_in_frame <= '0;
      end else if (flush) begin
        lines_in_frame <= lines_in_frame + 16'd1;
      end

      if (ovf_set)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) hold_data_p0 <= pix_data;
  end

  // Stage boundary: output FIFO, entry = {tuser, tlast, tdata}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= {wr_user, wr_last, hold_data_p0};
  end

  // Outputs read as zero whenever nothing is queued, including under reset.
  assign m_axis.tvalid = !empty;
  assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = empty ? '0 : mem[rd_ptr];

endmodule
